// File: rtl/box_blur_3x3_if.sv
// Pixel stream bundle between the line-buffer front end and the 3x3 box-blur compute stage.
// Carries the three row-aligned input columns and the blurred output stream.
interface box_blur_3x3_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] row0Pixel;
   logic [DATA_WIDTH-1:0] row1Pixel;
   logic [DATA_WIDTH-1:0] row2Pixel;
   logic                  inPixelValid;
   logic [DATA_WIDTH-1:0] outPixel;
   logic                  outPixelValid;
   logic                  lineDone;

   modport master (
      output row0Pixel, row1Pixel, row2Pixel, inPixelValid,
      input  outPixel, outPixelValid, lineDone
   );

   modport slave (
      input  row0Pixel, row1Pixel, row2Pixel, inPixelValid,
      output outPixel, outPixelValid, lineDone
   );
endinterface

// File: rtl/box_blur_3x3.sv
// 3x3 box-blur compute stage: sliding window over three row streams, emits floor(sum/9)
// for each complete window with a fixed three-cycle latency and no backpressure.
module box_blur_3x3 #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IMG_WIDTH  = 16
) (
   input logic            clk,
   input logic            rst,
   box_blur_3x3_if.slave  bus
);

   localparam int unsigned SUM_W = DATA_WIDTH + 4;
   localparam int unsigned CNT_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] win [3][3];   // [row][col], col0 is the newest column
   logic [CNT_W-1:0]      colCnt;
   logic                  atLastCol;
   logic                  s1Valid;
   logic                  s1Last;
   logic [SUM_W-1:0]      sumC;
   logic [SUM_W-1:0]      s2Sum;
   logic                  s2Valid;
   logic                  s2Last;

   assign atLastCol = (colCnt == CNT_W'(IMG_WIDTH - 1));

   // Stage 1: window shift, column counter, window-complete and last-column flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         colCnt  <= '0;
         s1Valid <= 1'b0;
         s1Last  <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else begin
         s1Valid <= bus.inPixelValid && (colCnt >= CNT_W'(2));
         s1Last  <= bus.inPixelValid && atLastCol;
         if (bus.inPixelValid) begin
            colCnt <= atLastCol ? '0 : colCnt + CNT_W'(1);
            for (int r = 0; r < 3; r++) begin
               win[r][2] <= win[r][1];
               win[r][1] <= win[r][0];
            end
            win[0][0] <= bus.row0Pixel;
            win[1][0] <= bus.row1Pixel;
            win[2][0] <= bus.row2Pixel;
         end
      end
   end

   always_comb begin
      sumC = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            sumC = sumC + SUM_W'(win[r][c]);
         end
      end
   end

   // Stage 2: registered nine-pixel sum
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2Sum   <= '0;
         s2Valid <= 1'b0;
         s2Last  <= 1'b0;
      end else begin
         s2Sum   <= sumC;
         s2Valid <= s1Valid;
         s2Last  <= s1Last;
      end
   end

   // Stage 3: exact truncating divide by nine; pixel holds while idle
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.outPixel      <= '0;
         bus.outPixelValid <= 1'b0;
         bus.lineDone      <= 1'b0;
      end else begin
         if (s2Valid) begin
            bus.outPixel <= DATA_WIDTH'(s2Sum / SUM_W'(9));
         end
         bus.outPixelValid <= s2Valid;
         bus.lineDone      <= s2Valid && s2Last;
      end
   end

endmodule

// File: tb/tb_box_blur_3x3.sv
// Bench for box_blur_3x3: directed and random column streams checked cycle by cycle
// against a row-buffer reference model that averages the last three columns of a row.
module tb_box_blur_3x3;

   localparam int unsigned DW = 8;
   localparam int unsigned W  = 16;

   logic clk = 1'b0;
   logic rst;

   box_blur_3x3_if #(.DATA_WIDTH(DW)) bus ();

   box_blur_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int val;
      bit last;
   } exp_t;

   exp_t expQ[$];
   int   r0[$];
   int   r1[$];
   int   r2[$];
   int   mCol        = 0;
   int   edgeN       = 0;
   int   lastOut     = 0;
   int   assertions  = 0;
   int   failures    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      assertions++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, edgeN);
      end
   endtask

   // One clock: drive inputs, update the reference model at the edge, then check outputs
   task automatic cycle(input bit rstV, input bit v, input int p0, input int p1, input int p2);
      int s;
      rst              = rstV;
      bus.inPixelValid = v;
      bus.row0Pixel    = DW'(p0);
      bus.row1Pixel    = DW'(p1);
      bus.row2Pixel    = DW'(p2);
      @(posedge clk);
      edgeN++;
      if (!rstV) begin
         expQ.delete();
         r0.delete();
         r1.delete();
         r2.delete();
         mCol    = 0;
         lastOut = 0;
      end else if (v) begin
         r0.push_back(p0);
         r1.push_back(p1);
         r2.push_back(p2);
         if (mCol >= 2) begin
            s = 0;
            for (int k = mCol - 2; k <= mCol; k++) s += r0[k] + r1[k] + r2[k];
            expQ.push_back('{edgeN + 2, s / 9, (mCol == int'(W) - 1)});
         end
         mCol++;
         if (mCol == int'(W)) begin
            mCol = 0;
            r0.delete();
            r1.delete();
            r2.delete();
         end
      end
      #1;
      if (expQ.size() > 0 && expQ[0].due == edgeN) begin
         chk("valid", 32'(bus.outPixelValid), 32'd1);
         chk("pixel", 32'(bus.outPixel), 32'(expQ[0].val));
         chk("lineDone", 32'(bus.lineDone), 32'(expQ[0].last));
         lastOut = expQ[0].val;
         void'(expQ.pop_front());
      end else begin
         chk("idleValid", 32'(bus.outPixelValid), 32'd0);
         chk("idleLineDone", 32'(bus.lineDone), 32'd0);
         chk("idleHold", 32'(bus.outPixel), 32'(lastOut));
      end
   endtask

   // mode 0: constant (c0,c1,c2); 1: ramp = column index; 2: random. gapMode 1: toggle; 2: random gaps
   task automatic sendCols(input int n, input int mode, input int c0, input int c1, input int c2,
                           input int gapMode);
      int i;
      bit gap;
      bit ph;
      i  = 0;
      ph = 1'b0;
      while (i < n) begin
         gap = 1'b0;
         if (gapMode == 1) begin
            gap = ph;
            ph  = ~ph;
         end else if (gapMode == 2) begin
            gap = ($urandom_range(0, 3) == 0);
         end
         if (gap) begin
            cycle(1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
         end else begin
            case (mode)
               0:       cycle(1'b1, 1'b1, c0, c1, c2);
               1:       cycle(1'b1, 1'b1, i % int'(W), i % int'(W), i % int'(W));
               default: cycle(1'b1, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                              int'($urandom_range(0, 255)));
            endcase
            i++;
         end
      end
   endtask

   initial begin
      rst              = 1'b0;
      bus.inPixelValid = 1'b0;
      bus.row0Pixel    = '0;
      bus.row1Pixel    = '0;
      bus.row2Pixel    = '0;

      // Reset held with valid columns present, then released while idle
      repeat (3) cycle(1'b0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)));
      repeat (3) cycle(1'b1, 1'b0, 0, 0, 0);

      // Constant image
      sendCols(W, 0, 100, 100, 100, 0);
      repeat (2) cycle(1'b1, 1'b0, 0, 0, 0);

      // Ramp, full scale and floor cases
      sendCols(W, 1, 0, 0, 0, 0);
      sendCols(W, 0, 255, 255, 255, 0);
      sendCols(W, 0, 255, 0, 0, 0);
      sendCols(W, 0, 1, 0, 0, 0);
      repeat (4) cycle(1'b1, 1'b0, 0, 0, 0);

      // Ramp with alternating valid gaps
      sendCols(W, 1, 0, 0, 0, 1);
      repeat (4) cycle(1'b1, 1'b0, 0, 0, 0);

      // Two ramp rows back to back
      sendCols(W, 1, 0, 0, 0, 0);
      sendCols(W, 1, 0, 0, 0, 0);
      repeat (4) cycle(1'b1, 1'b0, 0, 0, 0);

      // Reset after column 8 (with a colliding valid column), then a fresh constant row
      sendCols(9, 1, 0, 0, 0, 0);
      cycle(1'b0, 1'b1, 200, 200, 200);
      sendCols(W, 0, 50, 50, 50, 0);
      repeat (4) cycle(1'b1, 1'b0, 0, 0, 0);

      // Random pixels with random gaps over several rows
      sendCols(4 * W, 2, 0, 0, 0, 2);
      sendCols(2 * W, 2, 0, 0, 0, 0);

      repeat (5) cycle(1'b1, 1'b0, 0, 0, 0);
      chk("drained", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/box_blur_3x3.md
# box_blur_3x3

Downstream compute stage of the 3×3 box-blur pipeline. It consumes three row-aligned pixel streams, one from each line-buffer FIFO, and assembles a sliding 3×3 window in shift registers. For every fully populated window it emits the exact truncated mean of the nine pixels. The output is a valid-qualified pixel stream with an end-of-line marker, and the block applies no backpressure.

## Interface
Clocking and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-low.

Parameters:
- `DATA_WIDTH`, default 8: width of each pixel.
- `IMG_WIDTH`, default 16: pixels per image row. Must be ≥ 3.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-low reset. A low level sampled at a `clk` rising edge resets the block.
- `row0Pixel`, in, `DATA_WIDTH`: pixel from the oldest line (top of the window).
- `row1Pixel`, in, `DATA_WIDTH`: pixel from the middle line.
- `row2Pixel`, in, `DATA_WIDTH`: pixel from the newest line (bottom of the window).
- `inPixelValid`, in, 1: the three row pixels form one valid column this cycle.
- `outPixel`, out, `DATA_WIDTH`: blurred pixel.
- `outPixelValid`, out, 1: `outPixel` is valid this cycle (one-cycle strobe per pixel).
- `lineDone`, out, 1: high together with `outPixelValid` on the last output pixel of a row.

## Operation
- **Window shift.** On each `clk` edge where `inPixelValid`=1, the column {row0, row1, row2} shifts in: col2 ← col1, col1 ← col0, col0 ← new. When `inPixelValid`=0, the window, column counter and warm-up state hold.
- **Column counter.** `colCnt` has range 0..`IMG_WIDTH`-1 and increments on each accepted column. At `IMG_WIDTH`-1 it wraps to 0, and the next accepted column begins a new row.
- **Warm-up.** A window is complete when the accepted column has `colCnt` ≥ 2. Columns 0 and 1 of every row produce no output. Each row therefore yields exactly `IMG_WIDTH`-2 outputs, with no padding and no mixing across rows.
- **Arithmetic.**
  - `sum` is the nine-pixel sum, `DATA_WIDTH`+4 bits wide. Its maximum is 9×(2^`DATA_WIDTH`-1), so it cannot overflow.
  - `outPixel` = floor(`sum`/9), which always fits in `DATA_WIDTH`.
  - A reciprocal multiply-and-shift is permitted only if it is bit-exact to floor(`sum`/9) over the full `sum` range.
- **lineDone.** Asserted with the output produced by the window completed at `colCnt` = `IMG_WIDTH`-1.
- **No backpressure.** The pipeline always advances. The upstream controller must stop `inPixelValid` itself, using the line-buffer FIFOs' `progFull` handshake.
- **Reset.**
  - Outputs: `outPixel`=0, `outPixelValid`=0, `lineDone`=0.
  - Internal state: `colCnt`=0, window registers 0, all pipeline valid bits 0.
  - Reset asserted mid-row discards every in-flight result. The first accepted column after reset is column 0 and starts warm-up.

## Timing
- **Stage 1** (edge ending input cycle t): window and `colCnt` update; a window-complete flag and a last-column flag are registered.
- **Stage 2** (edge ending t+1): `sum` is registered, together with valid and lineDone bits.
- **Stage 3** (edge ending t+2): `outPixel`, `outPixelValid` and `lineDone` are registered.
- **Latency.** A completing column presented in cycle t gives an output visible in cycle t+3, fixed regardless of gaps.
- **Throughput.** One output per cycle when `inPixelValid` is held high.
- **Gaps.** An `inPixelValid` gap produces a matching gap in `outPixelValid`. Outputs already in flight still emerge on schedule.
- **Idle outputs.** When `outPixelValid`=0, `outPixel` holds its last value and `lineDone`=0.
- **Row boundary.** Back-to-back rows with no idle cycle are legal. The two warm-up columns of the new row produce a 2-cycle bubble in `outPixelValid`.
- **Simultaneous events.** `rst`=0 overrides `inPixelValid`=1 on the same edge; the column is dropped.

## Test plan
1. **Reset.** Drive `rst`=0 for 3 cycles with `inPixelValid`=1 and random pixels. Required: `outPixel`=0, `outPixelValid`=0 and `lineDone`=0 throughout, and for 3 cycles after release.
2. **Constant image.** All rows = 100 for 16 valid columns (`IMG_WIDTH`=16). Required: 14 outputs of 100. The first appears 3 cycles after column 2 is presented, and `lineDone` is high only on the 14th.
3. **Ramp, full-scale and floor.**
   - All rows = column index i (0..15). Required: outputs 1, 2, …, 14, i.e. i-1 for i=2..15.
   - All 255. Required: 255.
   - row0 = 255, others 0. Required: 85.
   - row0 = 1, others 0. Required: 0.
4. **Gapped input.** Repeat scenario 3's ramp with `inPixelValid` toggling 1/0. Required: the same 14-value sequence, each value exactly 3 cycles after its completing column, and no `outPixelValid` during gap-derived slots.
5. **Back-to-back rows.** Two consecutive ramp rows with no idle cycle. Required: 28 outputs, a 2-cycle `outPixelValid` bubble at the row boundary, and `lineDone` on outputs 14 and 28. No output may combine pixels from both rows.
6. **Reset mid-row.** Assert `rst`=0 for 1 cycle after column 8, then send a fresh constant-50 row. Required: no outputs from the aborted row after reset, then 14 outputs of 50 with `lineDone` on the last.
